// File: rtl/tcp_tmp_buf_pkg.sv
// tcp_tmp_buf_pkg -- shared geometry of the rx temporary payload buffer.
// Rev 1.0
`default_nettype none

package tcp_tmp_buf_pkg;

  localparam int NUM_SLABS       = 16;
  localparam int SLAB_BYTES_LOG2 = 11;
  localparam int SLAB_IDX_W      = $clog2(NUM_SLABS);
  localparam int BUF_ADDR_W      = SLAB_IDX_W + SLAB_BYTES_LOG2;

  typedef logic [SLAB_IDX_W-1:0] slab_idx_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } alloc_state_t;

endpackage

`default_nettype wire

// File: rtl/tcp_slab_free_list.sv
// tcp_slab_free_list -- circular FIFO of free slab indices with a combinational head read.
// Rev 1.0
`default_nettype none

module tcp_slab_free_list #(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  input  logic             pop,
  output logic [IDX_W-1:0] head_idx,
  output logic [IDX_W:0]   count
);

  logic [IDX_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0] head_ptr;
  logic [IDX_W-1:0] tail_ptr;

  // Storage needs no reset: every entry is rewritten before it can be read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail_ptr] <= push_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        tail_ptr <= tail_ptr + IDX_W'(1);
      end
      if (pop) begin
        head_ptr <= head_ptr + IDX_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (IDX_W+1)'(1);
        2'b01:   count <= count - (IDX_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_idx = mem[head_ptr];

endmodule

`default_nettype wire

// File: rtl/tcp_tmp_buf_slab_alloc.sv
// tcp_tmp_buf_slab_alloc -- offers free temp-buffer slabs to the rx controller and takes them back.
// Rev 1.0
`default_nettype none

module tcp_tmp_buf_slab_alloc
  import tcp_tmp_buf_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tmp_buf_alloc_slab_consume_val,
  output logic                  alloc_slab_tmp_buf_resp_error,
  output logic [BUF_ADDR_W-1:0] alloc_slab_tmp_buf_resp_addr,
  output logic [SLAB_IDX_W-1:0] alloc_slab_tmp_buf_resp_idx,
  input  logic                  src_alloc_free_val,
  input  logic [SLAB_IDX_W-1:0] src_alloc_free_idx,
  output logic                  alloc_src_free_rdy,
  output logic [SLAB_IDX_W:0]   alloc_free_cnt,
  output logic                  alloc_double_free_err
);

  alloc_state_t          state, state_next;
  slab_idx_t             init_cnt;
  logic [NUM_SLABS-1:0]  allocated;
  logic                  push, pop;
  slab_idx_t             push_idx;
  slab_idx_t             head_idx;
  logic [SLAB_IDX_W:0]   count;
  logic                  free_ok, free_dup;

  tcp_slab_free_list #(
    .DEPTH (NUM_SLABS),
    .IDX_W (SLAB_IDX_W)
  ) u_free_list (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_idx (push_idx),
    .pop      (pop),
    .head_idx (head_idx),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= ST_INIT;
      init_cnt              <= '0;
      allocated             <= '0;
      alloc_double_free_err <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + SLAB_IDX_W'(1);
      end
      // A slab being consumed is never also being validly freed, so the order is safe.
      if (free_ok) begin
        allocated[src_alloc_free_idx] <= 1'b0;
      end
      if (pop) begin
        allocated[head_idx] <= 1'b1;
      end
      if (free_dup) begin
        alloc_double_free_err <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next                    = state;
    push                          = 1'b0;
    push_idx                      = init_cnt;
    pop                           = 1'b0;
    free_ok                       = 1'b0;
    free_dup                      = 1'b0;
    alloc_slab_tmp_buf_resp_error = 1'b1;
    alloc_slab_tmp_buf_resp_idx   = '0;
    alloc_src_free_rdy            = 1'b0;
    case (state)
      ST_INIT: begin
        // Fill the list through the push port so tail wraps to 0 and count reaches NUM_SLABS.
        push = 1'b1;
        if (init_cnt == SLAB_IDX_W'(NUM_SLABS - 1)) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        alloc_slab_tmp_buf_resp_error = (count == '0);
        alloc_slab_tmp_buf_resp_idx   = head_idx;
        alloc_src_free_rdy            = 1'b1;
        pop      = tmp_buf_alloc_slab_consume_val && (count != '0);
        free_ok  = src_alloc_free_val && allocated[src_alloc_free_idx];
        free_dup = src_alloc_free_val && !allocated[src_alloc_free_idx];
        push     = free_ok;
        push_idx = src_alloc_free_idx;
      end
      default: state_next = ST_INIT;
    endcase
  end

  assign alloc_slab_tmp_buf_resp_addr = {alloc_slab_tmp_buf_resp_idx, {SLAB_BYTES_LOG2{1'b0}}};
  assign alloc_free_cnt               = count;

endmodule

`default_nettype wire

// File: tb/tb_tcp_tmp_buf_slab_alloc.sv
// tb_tcp_tmp_buf_slab_alloc -- directed stimulus with a queue-based free-list model checked every cycle.
// Rev 1.0
`default_nettype none

module tb_tcp_tmp_buf_slab_alloc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        consume_val = 1'b0;
  logic        resp_error;
  logic [14:0] resp_addr;
  logic [3:0]  resp_idx;
  logic        free_val = 1'b0;
  logic [3:0]  free_idx = '0;
  logic        free_rdy;
  logic [4:0]  free_cnt;
  logic        dfe;

  int errors = 0;
  int checks = 0;

  tcp_tmp_buf_slab_alloc dut (
    .clk                            (clk),
    .rst                            (rst),
    .tmp_buf_alloc_slab_consume_val (consume_val),
    .alloc_slab_tmp_buf_resp_error  (resp_error),
    .alloc_slab_tmp_buf_resp_addr   (resp_addr),
    .alloc_slab_tmp_buf_resp_idx    (resp_idx),
    .src_alloc_free_val             (free_val),
    .src_alloc_free_idx             (free_idx),
    .alloc_src_free_rdy             (free_rdy),
    .alloc_free_cnt                 (free_cnt),
    .alloc_double_free_err          (dfe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Model: a plain FIFO of free indices plus an "is allocated" set.
  int      m_q[$];
  bit [15:0] m_alloc;
  bit      m_dfe;
  int      m_init_left;
  bit      m_live = 1'b0;

  always @(posedge clk) begin
    bit can;
    int hd;
    if (rst) begin
      m_q.delete();
      m_init_left = 16;
      m_alloc     = '0;
      m_dfe       = 1'b0;
      m_live      = 1'b1;
    end else if (m_live) begin
      if (m_init_left > 0) begin
        m_init_left--;
        if (m_init_left == 0)
          for (int i = 0; i < 16; i++) m_q.push_back(i);
      end else begin
        can = consume_val && (m_q.size() > 0);
        hd  = can ? m_q[0] : 0;
        if (free_val) begin
          if (m_alloc[free_idx]) begin
            m_q.push_back(int'(free_idx));
            m_alloc[free_idx] = 1'b0;
          end else begin
            m_dfe = 1'b1;
          end
        end
        if (can) begin
          void'(m_q.pop_front());
          m_alloc[hd] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (m_live) begin
      check("cyc_dfe", int'(dfe), int'(m_dfe));
      if (m_init_left > 0) begin
        check("cyc_init_err", int'(resp_error), 1);
        check("cyc_init_idx", int'(resp_idx), 0);
        check("cyc_init_addr", int'(resp_addr), 0);
        check("cyc_init_rdy", int'(free_rdy), 0);
      end else begin
        check("cyc_err", int'(resp_error), int'(m_q.size() == 0));
        check("cyc_rdy", int'(free_rdy), 1);
        check("cyc_cnt", int'(free_cnt), m_q.size());
        if (m_q.size() > 0) begin
          check("cyc_idx", int'(resp_idx), m_q[0]);
          check("cyc_addr", int'(resp_addr), m_q[0] * 2048);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic cycle(input bit c, input bit f, input int fi);
    consume_val = c;
    free_val    = f;
    free_idx    = 4'(fi);
    tick();
    consume_val = 1'b0;
    free_val    = 1'b0;
  endtask

  task automatic poll_init();
    int n = 0;
    while (resp_error && n < 40) begin
      n++;
      tick();
    end
    check("init_len", n, 16);
  endtask

  initial begin
    int exp_ord[10];
    exp_ord = '{0, 1, 2, 4, 6, 8, 9, 10, 11, 3};

    tick();
    tick();
    rst = 1'b0;
    poll_init();
    check("run_err", int'(resp_error), 0);
    check("run_idx", int'(resp_idx), 0);
    check("run_addr", int'(resp_addr), 16'h0000);
    check("run_cnt", int'(free_cnt), 16);

    for (int i = 0; i < 16; i++) begin
      check("drain_idx", int'(resp_idx), i);
      check("drain_addr", int'(resp_addr), i * 16'h0800);
      cycle(1'b1, 1'b0, 0);
    end
    check("empty_err", int'(resp_error), 1);
    check("empty_cnt", int'(free_cnt), 0);
    cycle(1'b1, 1'b0, 0);
    check("over_err", int'(resp_error), 1);
    check("over_cnt", int'(free_cnt), 0);

    cycle(1'b0, 1'b1, 5);
    check("free5_err", int'(resp_error), 0);
    check("free5_idx", int'(resp_idx), 5);
    check("free5_addr", int'(resp_addr), 16'h2800);
    check("free5_cnt", int'(free_cnt), 1);

    foreach (exp_ord[k]) if (k < 9) cycle(1'b0, 1'b1, exp_ord[k]);
    check("ten_cnt", int'(free_cnt), 10);
    cycle(1'b1, 1'b1, 3);
    check("swap_cnt", int'(free_cnt), 10);
    foreach (exp_ord[k]) begin
      check("order_idx", int'(resp_idx), exp_ord[k]);
      cycle(1'b1, 1'b0, 0);
    end
    check("order_empty", int'(free_cnt), 0);

    cycle(1'b0, 1'b1, 7);
    check("free7_cnt", int'(free_cnt), 1);
    check("free7_dfe", int'(dfe), 0);
    cycle(1'b0, 1'b1, 7);
    check("dup7_cnt", int'(free_cnt), 1);
    check("dup7_dfe", int'(dfe), 1);
    tick();
    check("dup7_sticky", int'(dfe), 1);

    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    poll_init();
    check("rerun_cnt", int'(free_cnt), 16);
    check("rerun_idx", int'(resp_idx), 0);
    check("rerun_dfe", int'(dfe), 0);

    // Returning the slab that is being handed out this same cycle is a double free.
    cycle(1'b1, 1'b1, 0);
    check("samecyc_dfe", int'(dfe), 1);
    check("samecyc_cnt", int'(free_cnt), 15);
    check("samecyc_idx", int'(resp_idx), 1);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
